rf_wr_arbiter: RTL and testbench

Arbitrates the single register-file write port between the pipeline writeback stage and a multi-cycle execution unit (mul/div). Writeback results always win the port. Multi-cycle results that lose are held in a small in-order buffer and drain on idle cycles. A starvation counter raises a pipeline stall to force a drain, and a pending-destination query lets the hazard logic hold dependent instructions.

---
 rtl/rf_wr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: writeback always wins, multi-cycle results
// wait in an in-order buffer, with a starvation stall and pending-rd hazard query.
module rf_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        mu_valid_i,
    input  logic [4:0]  mu_rd_i,
    input  logic [31:0] mu_data_i,
    output logic        mu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
    output logic        stall_o,
    input  logic [4:0]  q_rs1_i,
    input  logic [4:0]  q_rs2_i,
    output logic        q_hit1_o,
    output logic        q_hit2_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);

    logic [CW-1:0] count_r;
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [DEPTH-1:0] live_r;
    logic [4:0]    rd_mem_r   [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [3:0]    starve_r;
    logic          stall_r;
    logic          rf_we_r;
    logic [4:0]    rf_rd_r;
    logic [31:0]   rf_data_r;

    logic          wbv_s, mu_ready_s, mu_acc_s, deq_s, byp_s, enq_s, pend_s;
    logic [DEPTH-1:0] live_nxt_s;
    logic [3:0]    starve_nxt_s;
    logic          rf_we_nxt_s;
    logic [4:0]    rf_rd_nxt_s;
    logic [31:0]   rf_data_nxt_s;
    logic          hit1_s, hit2_s;

    // Request decode and port-slot selection.
    always_comb begin
        wbv_s      = wb_we_i & (wb_rd_i != 5'd0);
        mu_ready_s = (count_r < FULL_CNT) & rst_n_i;
        mu_acc_s   = mu_valid_i & mu_ready_s;
        deq_s      = ~wbv_s & (count_r != {CW{1'b0}});
        // A younger WB write to the same rd makes the MU result obsolete.
        pend_s     = mu_acc_s & (mu_rd_i != 5'd0) & ~(wbv_s & (mu_rd_i == wb_rd_i));
        byp_s      = pend_s & ~wbv_s & (count_r == {CW{1'b0}});
        enq_s      = pend_s & ~byp_s;
    end

    // Next register-file write, in priority order WB / head / bypass / idle.
    always_comb begin
        rf_we_nxt_s   = 1'b0;
        rf_rd_nxt_s   = rf_rd_r;
        rf_data_nxt_s = rf_data_r;
        if (wbv_s) begin
            rf_we_nxt_s   = 1'b1;
            rf_rd_nxt_s   = wb_rd_i;
            rf_data_nxt_s = wb_data_i;
        end else if (deq_s) begin
            rf_we_nxt_s   = live_r[head_r];
            rf_rd_nxt_s   = rd_mem_r[head_r];
            rf_data_nxt_s = data_mem_r[head_r];
        end else if (byp_s) begin
            rf_we_nxt_s   = 1'b1;
            rf_rd_nxt_s   = mu_rd_i;
            rf_data_nxt_s = mu_data_i;
        end else begin
            rf_we_nxt_s   = 1'b0;
        end
    end

    // Live-bit update: WB kill, dequeue retire, enqueue arm.
    always_comb begin
        live_nxt_s = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (wbv_s && (rd_mem_r[i] == wb_rd_i)) begin
                live_nxt_s[i] = 1'b0;
            end else begin
                live_nxt_s[i] = live_nxt_s[i];
            end
        end
        if (deq_s) begin
            live_nxt_s[head_r] = 1'b0;
        end else begin
            live_nxt_s = live_nxt_s;
        end
        if (enq_s) begin
            live_nxt_s[tail_r] = 1'b1;
        end else begin
            live_nxt_s = live_nxt_s;
        end
    end

    // Starvation counter next value: cleared by a drain, saturating otherwise.
    always_comb begin
        if (deq_s) begin
            starve_nxt_s = 4'd0;
        end else if (wbv_s && (count_r != {CW{1'b0}}) && (starve_r < LIMIT)) begin
            starve_nxt_s = starve_r + 4'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // Pending-destination query over current live entries plus this cycle's accepted result.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_r[i] && (rd_mem_r[i] == q_rs1_i)) begin
                hit1_s = 1'b1;
            end else begin
                hit1_s = hit1_s;
            end
            if (live_r[i] && (rd_mem_r[i] == q_rs2_i)) begin
                hit2_s = 1'b1;
            end else begin
                hit2_s = hit2_s;
            end
        end
        hit1_s = (q_rs1_i != 5'd0) & (hit1_s | (pend_s & (mu_rd_i == q_rs1_i)));
        hit2_s = (q_rs2_i != 5'd0) & (hit2_s | (pend_s & (mu_rd_i == q_rs2_i)));
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_r   <= {CW{1'b0}};
            head_r    <= {AW{1'b0}};
            tail_r    <= {AW{1'b0}};
            live_r    <= {DEPTH{1'b0}};
            starve_r  <= 4'd0;
            stall_r   <= 1'b0;
            rf_we_r   <= 1'b0;
            rf_rd_r   <= 5'd0;
            rf_data_r <= 32'd0;
        end else begin
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            head_r    <= deq_s ? head_r + AW'(1) : head_r;
            tail_r    <= enq_s ? tail_r + AW'(1) : tail_r;
            live_r    <= live_nxt_s;
            starve_r  <= starve_nxt_s;
            stall_r   <= (starve_nxt_s == LIMIT);
            rf_we_r   <= rf_we_nxt_s;
            rf_rd_r   <= rf_rd_nxt_s;
            rf_data_r <= rf_data_nxt_s;
        end
    end

    // Buffer payload storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else if (enq_s) begin
            rd_mem_r[tail_r]   <= mu_rd_i;
            data_mem_r[tail_r] <= mu_data_i;
        end else begin
            rd_mem_r[tail_r]   <= rd_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    assign mu_ready_o = mu_ready_s;
    assign rf_we_o    = rf_we_r;
    assign rf_rd_o    = rf_rd_r;
    assign rf_data_o  = rf_data_r;
    assign stall_o    = stall_r;
    assign q_hit1_o   = hit1_s;
    assign q_hit2_o   = hit2_s;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed and randomized bench for rf_wr_arbiter against a queue-based model
// of the arbitration, kill and starvation rules.
module tb_rf_wr_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        wb_we_i, mu_valid_i;
    logic [4:0]  wb_rd_i, mu_rd_i, q_rs1_i, q_rs2_i, rf_rd_o;
    logic [31:0] wb_data_i, mu_data_i, rf_data_o;
    logic        mu_ready_o, rf_we_o, stall_o, q_hit1_o, q_hit2_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    int          st;
    logic        e_we, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    always #5 clk_i = ~clk_i;

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .mu_valid_i(mu_valid_i), .mu_rd_i(mu_rd_i), .mu_data_i(mu_data_i),
        .mu_ready_o(mu_ready_o),
        .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
        .stall_o(stall_o),
        .q_rs1_i(q_rs1_i), .q_rs2_i(q_rs2_i),
        .q_hit1_o(q_hit1_o), .q_hit2_o(q_hit2_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        wb_we_i = we; wb_rd_i = wrd; wb_data_i = wd;
        mu_valid_i = mv; mu_rd_i = mrd; mu_data_i = md;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic do_cycle();
        logic wbv, acc, pend, byp, nonempty, popped, h1, h2;
        ent_t e;
        #1;
        wbv      = wb_we_i && (wb_rd_i != 5'd0);
        acc      = mu_valid_i && (mq.size() < DEPTH);
        pend     = acc && (mu_rd_i != 5'd0) && !(wbv && (mu_rd_i == wb_rd_i));
        nonempty = (mq.size() != 0);
        byp      = pend && !wbv && !nonempty;
        h1 = pend && (mu_rd_i == q_rs1_i);
        h2 = pend && (mu_rd_i == q_rs2_i);
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].rd == q_rs1_i) h1 = 1'b1;
            if (mq[i].live && mq[i].rd == q_rs2_i) h2 = 1'b1;
        end
        h1 = h1 && (q_rs1_i != 5'd0);
        h2 = h2 && (q_rs2_i != 5'd0);
        chk("mu_ready", 32'(mu_ready_o), 32'(mq.size() < DEPTH));
        chk("q_hit1", 32'(q_hit1_o), 32'(h1));
        chk("q_hit2", 32'(q_hit2_o), 32'(h2));

        popped = 1'b0;
        if (wbv) begin
            e_we = 1'b1; e_rd = wb_rd_i; e_data = wb_data_i;
        end else if (nonempty) begin
            e = mq.pop_front();
            e_we = e.live; e_rd = e.rd; e_data = e.data;
            popped = 1'b1;
        end else if (byp) begin
            e_we = 1'b1; e_rd = mu_rd_i; e_data = mu_data_i;
        end else begin
            e_we = 1'b0;
        end
        if (wbv) begin
            foreach (mq[i]) if (mq[i].rd == wb_rd_i) mq[i].live = 1'b0;
        end
        if (pend && !byp) mq.push_back('{1'b1, mu_rd_i, mu_data_i});
        if (popped) st = 0;
        else if (nonempty && wbv && st < LIMIT) st++;
        e_stall = (st == LIMIT);

        @(posedge clk_i); #1;
        chk("rf_we", 32'(rf_we_o), 32'(e_we));
        if (e_we) begin
            chk("rf_rd", 32'(rf_rd_o), 32'(e_rd));
            chk("rf_data", rf_data_o, e_data);
        end
        chk("stall", 32'(stall_o), 32'(e_stall));
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst_n_i = 1'b0;
        #1;
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd_o), 32'd0);
        chk("rst_rf_data", rf_data_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_mu_ready", 32'(mu_ready_o), 32'd0);
        mq.delete(); st = 0; e_we = 1'b0; e_stall = 1'b0;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        q_rs1_i = 5'd0; q_rs2_i = 5'd0;
        do_reset();
        chk("post_rst_ready", 32'(mu_ready_o), 32'd1);

        // Bypass of an MU result on an idle WB slot.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF); do_cycle();
        chk("byp_rd", 32'(rf_rd_o), 32'd5);
        chk("byp_data", rf_data_o, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); do_cycle();
        chk("byp_empty", 32'(rf_we_o), 32'd0);

        // WB priority, then in-order drain.
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11); do_cycle();
        drive(1'b1, 5'd3, 32'h34, 1'b1, 5'd8, 32'h22); do_cycle();
        drive(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'd0);  do_cycle();
        chk("prio_full", 32'(mu_ready_o), 32'd0);
        chk("prio_wb_rd", 32'(rf_rd_o), 32'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); do_cycle();
        chk("drain1_rd", 32'(rf_rd_o), 32'd7);
        do_cycle();
        chk("drain2_rd", 32'(rf_rd_o), 32'd8);
        chk("drain2_data", rf_data_o, 32'h22);

        // Kill of a buffered entry by a younger WB write.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hAA); do_cycle();
        q_rs1_i = 5'd9;
        drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0); #1;
        chk("kill_hit_before", 32'(q_hit1_o), 32'd1);
        do_cycle();
        chk("kill_data", rf_data_o, 32'hBB);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); #1;
        chk("kill_hit_after", 32'(q_hit1_o), 32'd0);
        do_cycle();
        chk("kill_dead_slot", 32'(rf_we_o), 32'd0);
        q_rs1_i = 5'd0;

        // Starvation stall.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd10, 32'h1010); do_cycle();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            chk("starve_stall", 32'(stall_o), (i >= 3) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); do_cycle();
        chk("starve_drain_rd", 32'(rf_rd_o), 32'd10);
        chk("starve_release", 32'(stall_o), 32'd0);

        // rd=0 on both sources.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'h1111); do_cycle();
        drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);    do_cycle();
        chk("rd0_drain_rd", 32'(rf_rd_o), 32'd11);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0); do_cycle();
        chk("rd0_no_write", 32'(rf_we_o), 32'd0);

        // Reset with two buffered entries.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'h12); do_cycle();
        drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd13, 32'h13); do_cycle();
        do_reset();
        chk("rst2_ready", 32'(mu_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            chk("rst2_no_stale", 32'(rf_we_o), 32'd0);
        end

        // Randomized traffic with a narrow rd range to force collisions.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
            q_rs1_i = 5'($urandom_range(0, 7));
            q_rs2_i = 5'($urandom_range(0, 7));
            do_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
